// File: rtl/rv32im_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : rv32im_prefetch_queue
// Purpose  : Multi-entry instruction prefetch unit. Fetches sequential words
//            over the shared Wishbone-style bus into a DEPTH-entry FIFO and
//            presents the head entry (instruction, PC, error flag) to decode.
//            Supports redirect/flush and yields the bus on bus_hold_i.
// Ports    : clk_i, reset_i            - clock, synchronous active-high reset
//            redirect_i, redirect_pc_i - flush queue, restart fetch at new PC
//            pop_i, valid_o            - consumer handshake on head entry
//            instruction_o, pc_o,
//            fetch_err_o               - head entry fields
//            bus_hold_i                - block new bus issue
//            master_dat_i, ack_i, err_i- bus response
//            adr_o, sel_o, stb_o,
//            busy_o                    - bus request
// Options  : PREFETCH_BYPASS_EN - present the bus word combinationally in the
//            ack cycle when the queue is empty.
// Revision : 1.0 - initial release
// ============================================================================
module rv32im_prefetch_queue #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter int               PTR_BITS = 2,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [XLEN-1:0]   instruction_o,
  output logic [XLEN-1:0]   pc_o,
  output logic              fetch_err_o,
  input  logic              bus_hold_i,
  input  logic [XLEN-1:0]   master_dat_i,
  input  logic              ack_i,
  input  logic              err_i,
  output logic [XLEN-3:0]   adr_o,
  output logic [3:0]        sel_o,
  output logic              stb_o,
  output logic              busy_o
);

  localparam logic [1:0]          c_IDLE    = 2'd0;
  localparam logic [1:0]          c_FETCH   = 2'd1;
  localparam logic [1:0]          c_DISCARD = 2'd2;
  localparam logic [1:0]          c_HALT    = 2'd3;
  localparam logic [PTR_BITS:0]   c_DEPTH   = (PTR_BITS+1)'(DEPTH);

  logic [1:0]          state_q, state_d;
  logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
  logic [XLEN-3:0]     adr_q, adr_d;
  logic                stb_q, stb_d;
  logic [PTR_BITS:0]   count_q, count_d;
  logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;

  logic [XLEN-1:0]     instr_mem_q [DEPTH];
  logic [XLEN-1:0]     pc_mem_q    [DEPTH];
  logic                err_mem_q   [DEPTH];

  logic w_fetch_done;
  logic w_bypass;
  logic w_push;
  logic w_pop;
  logic w_issue;

  // A response ends the outstanding transaction only while we strobe.
  assign w_fetch_done = (state_q == c_FETCH) && stb_q && (ack_i || err_i);

`ifdef PREFETCH_BYPASS_EN
  assign w_bypass = (state_q == c_FETCH) && stb_q && ack_i && !err_i &&
                    !redirect_i && (count_q == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word popped in its ack cycle never touches storage.
  assign w_push = w_fetch_done && !redirect_i && !(w_bypass && pop_i);
  assign w_pop  = pop_i && (count_q != '0) && !redirect_i;

  always_comb begin
    count_d = count_q + (PTR_BITS+1)'(w_push) - (PTR_BITS+1)'(w_pop);
    if (redirect_i) begin
      count_d = '0;
    end
  end

  // Issue only if a slot stays free after this cycle's push/pop; the
  // in-flight word then always has room, so a push never meets a full queue.
  assign w_issue = (count_d < c_DEPTH) && !bus_hold_i && !redirect_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    adr_d      = adr_q;
    stb_d      = stb_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~XLEN'(3);
      if (stb_q && !(ack_i || err_i)) begin
        // Transaction still open: keep the strobe, drop its response later.
        state_d = c_DISCARD;
      end else begin
        state_d = c_IDLE;
        stb_d   = 1'b0;
      end
    end else begin
      case (state_q)
        c_IDLE: begin
          if (w_issue) begin
            state_d = c_FETCH;
            stb_d   = 1'b1;
            adr_d   = fetch_pc_q[XLEN-1:2];
          end
        end
        c_FETCH: begin
          if (err_i) begin
            state_d = c_HALT;
            stb_d   = 1'b0;
          end else if (ack_i) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (w_issue) begin
              adr_d = fetch_pc_d[XLEN-1:2];
            end else begin
              state_d = c_IDLE;
              stb_d   = 1'b0;
            end
          end
        end
        c_DISCARD: begin
          if (ack_i || err_i) begin
            state_d = c_IDLE;
            stb_d   = 1'b0;
          end
        end
        c_HALT: begin
          state_d = c_HALT;
        end
        default: begin
          state_d = c_IDLE;
          stb_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= c_IDLE;
      fetch_pc_q <= RESET_PC;
      adr_q      <= '0;
      stb_q      <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      adr_q      <= adr_d;
      stb_q      <= stb_d;
      count_q    <= count_d;
      if (redirect_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (w_push) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
        if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
      end
    end
  end

  // Entry storage needs no reset: valid_o gates every read.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      instr_mem_q[wr_ptr_q] <= err_i ? '0 : master_dat_i;
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      err_mem_q[wr_ptr_q]   <= err_i;
    end
  end

`ifdef PREFETCH_BYPASS_EN
  assign valid_o       = (count_q != '0) || w_bypass;
  assign instruction_o = w_bypass ? master_dat_i : instr_mem_q[rd_ptr_q];
  assign pc_o          = w_bypass ? fetch_pc_q   : pc_mem_q[rd_ptr_q];
`else
  assign valid_o       = (count_q != '0);
  assign instruction_o = instr_mem_q[rd_ptr_q];
  assign pc_o          = pc_mem_q[rd_ptr_q];
`endif
  assign fetch_err_o   = (count_q != '0) && err_mem_q[rd_ptr_q];

  assign adr_o  = adr_q;
  assign sel_o  = stb_q ? 4'b1111 : 4'b0000;
  assign stb_o  = stb_q;
  assign busy_o = stb_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32im_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32im_prefetch_queue
// Purpose  : Self-checking bench for rv32im_prefetch_queue. A bus responder
//            and a consumer run inside a per-cycle tick task; expected entries
//            are queued when the bus answers and compared when decode pops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32im_prefetch_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        err;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        pop_i = 1'b0;
  logic        valid_o;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        fetch_err_o;
  logic        bus_hold_i = 1'b0;
  logic [31:0] master_dat_i = '0;
  logic        ack_i = 1'b0;
  logic        err_i = 1'b0;
  logic [29:0] adr_o;
  logic [3:0]  sel_o;
  logic        stb_o;
  logic        busy_o;

  rv32im_prefetch_queue #(
    .XLEN(32), .DEPTH(4), .PTR_BITS(2), .RESET_PC(32'h0)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .pop_i(pop_i), .valid_o(valid_o),
    .instruction_o(instruction_o), .pc_o(pc_o), .fetch_err_o(fetch_err_o),
    .bus_hold_i(bus_hold_i), .master_dat_i(master_dat_i), .ack_i(ack_i),
    .err_i(err_i), .adr_o(adr_o), .sel_o(sel_o), .stb_o(stb_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  int          wcnt = 0;
  int          discard = 0;
  int          pops = 0;
  int          stb_seen;
  bit          pop_en = 1'b0;
  bit          resp_now = 1'b0;
  bit          err_arm = 1'b0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] err_pc = 32'h0;
  ent_t        sb[$];
  ent_t        head;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'h200) ? 32'h0000_0013 : (32'hC0DE_0000 ^ a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: bus responder, then (after settling) the consumer.
  task automatic tick();
    @(negedge clk_i);
    redirect_i = 1'b0;
    resp_now   = 1'b0;
    if (ack_i || err_i) begin
      ack_i = 1'b0;
      err_i = 1'b0;
      wcnt  = 0;
    end
    if (stb_o === 1'b1) begin
      if (wcnt >= lat) begin
        resp_now = 1'b1;
        chk("sel", {28'h0, sel_o}, 32'hF);
        chk("busy", {31'h0, busy_o}, 32'h1);
        if (discard > 0) begin
          discard--;
          ack_i = 1'b1;
          master_dat_i = 32'hDEAD_BEEF;
        end else begin
          chk("adr", {2'b00, adr_o}, {2'b00, exp_pc[31:2]});
          if (err_arm && exp_pc == err_pc) begin
            err_i = 1'b1;
            master_dat_i = 32'hBAD0_0BAD;
            sb.push_back('{pc: exp_pc, ins: 32'h0, err: 1'b1});
          end else begin
            ack_i = 1'b1;
            master_dat_i = word(exp_pc);
            sb.push_back('{pc: exp_pc, ins: word(exp_pc), err: 1'b0});
            exp_pc = exp_pc + 32'd4;
          end
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    #1;
    pop_i = pop_en;
    if (pop_en && valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("pop_underflow", 32'h1, 32'h0);
      end else begin
        head = sb.pop_front();
        chk("pop_pc", pc_o, head.pc);
        chk("pop_ins", instruction_o, head.ins);
        chk("pop_err", {31'h0, fetch_err_o}, {31'h0, head.err});
        pops++;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_stb", {31'h0, stb_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_err", {31'h0, fetch_err_o}, 32'h0);
    chk("rst_adr", {2'b00, adr_o}, 32'h0);
    chk("rst_sel", {28'h0, sel_o}, 32'h0);
    reset_i = 1'b0;

    // Fill with no pop: four fetches at adr 0..3, then the bus goes quiet
    lat = 1;
    repeat (30) tick();
    chk("fill_count", sb.size(), 32'd4);
    stb_seen = 0;
    repeat (5) begin
      tick();
      if (stb_o !== 1'b0) stb_seen++;
    end
    chk("full_no_stb", stb_seen, 32'd0);
    chk("full_valid", {31'h0, valid_o}, 32'h1);
    chk("full_pc", pc_o, 32'h0);
    chk("full_ins", instruction_o, word(32'h0));

    // Pop every cycle: continuous single-cycle fetches
    lat = 0;
    pops = 0;
    pop_en = 1'b1;
    repeat (40) tick();
    chk("stream_rate", {31'h0, pops >= 30}, 32'h1);
    pop_en = 1'b0;
    repeat (10) tick();

    // Redirect with a transaction in flight; its response is dropped
    lat = 2;
    pop_en = 1'b1;
    for (int i = 0; i < 20 && stb_o !== 1'b1; i++) tick();
    chk("redir_wait_stb", {31'h0, stb_o}, 32'h1);
    pop_en = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h103;
    sb.delete();
    discard = 1;
    exp_pc = 32'h100;
    tick();
    chk("redir_flush", {31'h0, valid_o}, 32'h0);
    pop_en = 1'b1;
    repeat (25) tick();
    chk("redir_discarded", discard, 32'd0);

    // Bus error at 0x20 halts fetch until the next redirect
    pop_en = 1'b0;
    repeat (30) tick();
    chk("pre_err_idle", {31'h0, stb_o}, 32'h0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h20;
    sb.delete();
    exp_pc = 32'h20;
    err_pc = 32'h20;
    err_arm = 1'b1;
    lat = 1;
    repeat (8) tick();
    chk("err_valid", {31'h0, valid_o}, 32'h1);
    chk("err_flag", {31'h0, fetch_err_o}, 32'h1);
    chk("err_pc", pc_o, 32'h20);
    chk("err_ins", instruction_o, 32'h0);
    stb_seen = 0;
    repeat (10) begin
      tick();
      if (stb_o !== 1'b0) stb_seen++;
    end
    chk("halt_no_stb", stb_seen, 32'd0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h80;
    sb.delete();
    exp_pc = 32'h80;
    err_arm = 1'b0;
    pop_en = 1'b1;
    repeat (20) tick();
    chk("resume_progress", {31'h0, exp_pc > 32'h80}, 32'h1);

    // Bus hold mid-strobe: current fetch completes, no new issue until release
    lat = 3;
    for (int i = 0; i < 20 && stb_o !== 1'b1; i++) tick();
    chk("hold_wait_stb", {31'h0, stb_o}, 32'h1);
    bus_hold_i = 1'b1;
    for (int i = 0; i < 10 && stb_o !== 1'b0; i++) tick();
    chk("hold_completes", {31'h0, stb_o}, 32'h0);
    stb_seen = 0;
    repeat (8) begin
      tick();
      if (stb_o !== 1'b0) stb_seen++;
    end
    chk("hold_no_stb", stb_seen, 32'd0);
    bus_hold_i = 1'b0;
    tick();
    chk("hold_release", {31'h0, stb_o}, 32'h1);

    // Empty queue, ack with 0x00000013: bypass timing
    pop_en = 1'b0;
    bus_hold_i = 1'b1;
    for (int i = 0; i < 20 && stb_o !== 1'b0; i++) tick();
    chk("byp_idle", {31'h0, stb_o}, 32'h0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h200;
    bus_hold_i = 1'b0;
    sb.delete();
    exp_pc = 32'h200;
    lat = 0;
    tick();
    for (int i = 0; i < 10 && !resp_now; i++) tick();
    chk("byp_resp", {31'h0, resp_now}, 32'h1);
`ifdef PREFETCH_BYPASS_EN
    chk("byp_valid_ack", {31'h0, valid_o}, 32'h1);
    chk("byp_ins_ack", instruction_o, 32'h0000_0013);
    chk("byp_pc_ack", pc_o, 32'h200);
`else
    chk("nobyp_valid_ack", {31'h0, valid_o}, 32'h0);
`endif
    tick();
    chk("byp_valid_next", {31'h0, valid_o}, 32'h1);
    chk("byp_ins_next", instruction_o, 32'h0000_0013);
    chk("byp_pc_next", pc_o, 32'h200);
    pop_en = 1'b1;
    repeat (15) tick();
    pop_en = 1'b0;
    bus_hold_i = 1'b1;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
